// File: rtl/alu_uart_interface_if.sv
// Bundle of the UART-side and ALU-side signals of the ALU byte-stream front end.
//   rx_data/rx_done        : byte and strobe from uart_rx
//   BusA/BusB/OpCode       : operands and opcode presented to the ALU
//   Result                 : combinational ALU result
//   tx_data/tx_start       : byte and start strobe to uart_tx
//   tx_done                : byte-sent strobe from uart_tx
//   busy/overrun           : frame-in-progress flag and sticky dropped-byte flag
// The master modport is the sequencer; the slave modport is its environment.
interface alu_uart_interface_if #(
    parameter int unsigned N = 7
);
    logic [7:0] rx_data;
    logic       rx_done;
    logic [N:0] BusA;
    logic [N:0] BusB;
    logic [5:0] OpCode;
    logic [N:0] Result;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       busy;
    logic       overrun;

    modport master (
        input  rx_data, rx_done, Result, tx_done,
        output BusA, BusB, OpCode, tx_data, tx_start, busy, overrun
    );

    modport slave (
        output rx_data, rx_done, Result, tx_done,
        input  BusA, BusB, OpCode, tx_data, tx_start, busy, overrun
    );
endinterface

// File: rtl/alu_uart_interface.sv
// Byte-stream front end for the ALU: collects operand A, operand B and opcode
// from uart_rx, presents them to the ALU on registered buses, captures the
// ALU result one cycle later and hands it to uart_tx.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : master side of alu_uart_interface_if (all other signals)
module alu_uart_interface #(
    parameter int unsigned N       = 7,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TW      = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_uart_interface_if.master bus
);
    localparam int unsigned W = N + 1;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        CALC,
        WAIT_TX
    } state_t;

    state_t        state_q, state_n;
    logic [W-1:0]  bus_a_q, bus_a_n;
    logic [W-1:0]  bus_b_q, bus_b_n;
    logic [5:0]    op_q, op_n;
    logic [7:0]    tx_data_q, tx_data_n;
    logic          tx_start_q, tx_start_n;
    logic          busy_q, busy_n;
    logic          overrun_q, overrun_n;
    logic [TW-1:0] tmo_q, tmo_n;
    logic          tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    // Next-state and next-output logic
    always_comb begin
        state_n    = state_q;
        bus_a_n    = bus_a_q;
        bus_b_n    = bus_b_q;
        op_n       = op_q;
        tx_data_n  = tx_data_q;
        tx_start_n = 1'b0;
        overrun_n  = overrun_q;

        case (state_q)
            WAIT_A: begin
                if (bus.rx_done) begin
                    bus_a_n = W'(bus.rx_data);
                    state_n = WAIT_B;
                end
            end
            WAIT_B: begin
                // A byte arriving on the timeout cycle still wins
                if (bus.rx_done) begin
                    bus_b_n = W'(bus.rx_data);
                    state_n = WAIT_OP;
                end else if (tmo_hit) begin
                    state_n = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (bus.rx_done) begin
                    op_n    = bus.rx_data[5:0];
                    state_n = CALC;
                end else if (tmo_hit) begin
                    state_n = WAIT_A;
                end
            end
            CALC: begin
                tx_data_n  = 8'(bus.Result);
                tx_start_n = 1'b1;
                state_n    = WAIT_TX;
                if (bus.rx_done) begin
                    overrun_n = 1'b1;
                end
            end
            WAIT_TX: begin
                // A byte here is dropped even when tx_done lands on the same cycle
                if (bus.rx_done) begin
                    overrun_n = 1'b1;
                end
                if (bus.tx_done) begin
                    state_n = WAIT_A;
                end
            end
            default: begin
                state_n = WAIT_A;
            end
        endcase

        busy_n = (state_n != WAIT_A);

        // Inter-byte timer only runs while a frame is partially received
        if ((state_n != state_q) || bus.rx_done) begin
            tmo_n = '0;
        end else if ((state_q == WAIT_B) || (state_q == WAIT_OP)) begin
            tmo_n = tmo_q + TW'(1);
        end else begin
            tmo_n = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_A;
            bus_a_q    <= '0;
            bus_b_q    <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_n;
            bus_a_q    <= bus_a_n;
            bus_b_q    <= bus_b_n;
            op_q       <= op_n;
            tx_data_q  <= tx_data_n;
            tx_start_q <= tx_start_n;
            busy_q     <= busy_n;
            overrun_q  <= overrun_n;
            tmo_q      <= tmo_n;
        end
    end

    assign bus.BusA     = bus_a_q;
    assign bus.BusB     = bus_b_q;
    assign bus.OpCode   = op_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;
endmodule
